// File: rtl/frodo_mem_pkg.sv
// rtl/frodo_mem_pkg.sv - shared word width, row strides, index helper and server states
package frodo_mem_pkg;

  localparam int WORD_W        = 64;
  localparam int A_ROW_STRIDE  = 8;
  localparam int SE_ROW_STRIDE = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENGINE,
    ST_HOST_RSP
  } srv_state_e;

  // Byte address to 64-bit word index; callers zero-extend to 64 bits first.
  function automatic logic [63:0] word_index(input logic [63:0] byte_addr);
    return byte_addr >> 3;
  endfunction

endpackage

// File: rtl/frodo_bram_server_if.sv
// rtl/frodo_bram_server_if.sv - engine read/save ports plus host load/dump port
interface frodo_bram_server_if #(parameter int ADDR_W = 32);
  import frodo_mem_pkg::*;

  logic [ADDR_W-1:0] bram_addr_1, bram_addr_2, bram_addr_3;
  logic [WORD_W-1:0] bram_data_1, bram_data_2, bram_data_3;
  logic              save_wen;
  logic [WORD_W-1:0] save_data;
  logic              engine_busy;
  logic              host_req_valid, host_req_ready, host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [WORD_W-1:0] host_wdata;
  logic              host_rvalid;
  logic [WORD_W-1:0] host_rdata;
  logic              err_oor, err_align;
  logic [15:0]       wr_count;

  modport slave (
    input  bram_addr_1, bram_addr_2, bram_addr_3, save_wen, save_data, engine_busy,
           host_req_valid, host_we, host_addr, host_wdata,
    output bram_data_1, bram_data_2, bram_data_3, host_req_ready, host_rvalid,
           host_rdata, err_oor, err_align, wr_count
  );

  modport master (
    output bram_addr_1, bram_addr_2, bram_addr_3, save_wen, save_data, engine_busy,
           host_req_valid, host_we, host_addr, host_wdata,
    input  bram_data_1, bram_data_2, bram_data_3, host_req_ready, host_rvalid,
           host_rdata, err_oor, err_align, wr_count
  );

endinterface

// File: rtl/frodo_bram_server_word_array.sv
// rtl/frodo_bram_server_word_array.sv - word storage, three synchronous read ports, one write port, read-first
module frodo_word_array
  import frodo_mem_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic [2:0][IDX_W-1:0]   rd_idx_i,
  output logic [2:0][WORD_W-1:0]  rd_data_o,
  input  logic                    wr_en_i,
  input  logic [IDX_W-1:0]        wr_idx_i,
  input  logic [WORD_W-1:0]       wr_data_i
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Reads sample the array before the same-edge write lands, giving read-first.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 3; p++) rd_data_o[p] <= mem_q[rd_idx_i[p]];
    if (wr_en_i) mem_q[wr_idx_i] <= wr_data_i;
  end

endmodule

// File: rtl/frodo_bram_server.sv
// rtl/frodo_bram_server.sv - BRAM responder for the systolic controller with host load/dump access
module frodo_bram_server
  import frodo_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int ADDR_W      = 32
) (
  input logic                clk,
  input logic                rst_n,
  frodo_bram_server_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  srv_state_e               state_q, state_d;
  logic                     busy_q, eng_q;
  logic [2:0]               rd_ok_q, rd_ok_d;
  logic                     err_oor_q, err_align_q;
  logic [15:0]              wr_count_q, wr_count_d;
  logic [ADDR_W-1:0]        eng_addr [3];
  logic [63:0]              eng_idx [3];
  logic [2:0]               eng_oor, eng_mis;
  logic [63:0]              host_idx;
  logic                     host_oor, host_mis, host_acc, engine_act;
  logic                     oor_hit, mis_hit;
  logic [2:0][IDX_W-1:0]    rd_idx;
  logic [2:0][WORD_W-1:0]   rd_data;
  logic                     wr_en;
  logic [IDX_W-1:0]         wr_idx;
  logic [WORD_W-1:0]        wr_data;

  assign eng_addr[0] = bus.bram_addr_1;
  assign eng_addr[1] = bus.bram_addr_2;
  assign eng_addr[2] = bus.bram_addr_3;

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      eng_idx[p] = word_index(64'(eng_addr[p]));
      eng_oor[p] = |(eng_idx[p] >> IDX_W);
      eng_mis[p] = |eng_addr[p][2:0];
    end
    host_idx = word_index(64'(bus.host_addr));
    host_oor = |(host_idx >> IDX_W);
    host_mis = |bus.host_addr[2:0];
  end

  assign engine_act         = (state_q == ST_ENGINE);
  assign bus.host_req_ready = rst_n && (state_q == ST_IDLE) && !bus.engine_busy;
  assign host_acc           = bus.host_req_valid && bus.host_req_ready;

  // Host traffic borrows read port 1 and the write port whenever the engine is not running.
  assign rd_idx[0] = engine_act ? eng_idx[0][IDX_W-1:0] : host_idx[IDX_W-1:0];
  assign rd_idx[1] = eng_idx[1][IDX_W-1:0];
  assign rd_idx[2] = eng_idx[2][IDX_W-1:0];
  assign wr_en     = engine_act ? (bus.save_wen && !eng_oor[1])
                                : (host_acc && bus.host_we && !host_oor);
  assign wr_idx    = engine_act ? eng_idx[1][IDX_W-1:0] : host_idx[IDX_W-1:0];
  assign wr_data   = engine_act ? bus.save_data : bus.host_wdata;

  frodo_word_array #(.DEPTH(DEPTH_WORDS), .IDX_W(IDX_W)) u_array (
    .clk       (clk),
    .rd_idx_i  (rd_idx),
    .rd_data_o (rd_data),
    .wr_en_i   (wr_en),
    .wr_idx_i  (wr_idx),
    .wr_data_i (wr_data)
  );

  assign rd_ok_d = engine_act ? ~eng_oor : {2'b00, host_acc && !bus.host_we && !host_oor};
  assign oor_hit = (engine_act && |eng_oor) || (host_acc && host_oor);
  assign mis_hit = (engine_act && |eng_mis) || (host_acc && host_mis);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.engine_busy) state_d = ST_ENGINE;
        else if (host_acc && !bus.host_we) state_d = ST_HOST_RSP;
      end
      ST_ENGINE:   if (!bus.engine_busy) state_d = ST_IDLE;
      ST_HOST_RSP: state_d = bus.engine_busy ? ST_ENGINE : ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_count_d = wr_count_q;
    if (bus.engine_busy && !busy_q) wr_count_d = '0;
    else if (engine_act && bus.save_wen && (wr_count_q != 16'hFFFF))
      wr_count_d = wr_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      eng_q       <= 1'b0;
      rd_ok_q     <= '0;
      err_oor_q   <= 1'b0;
      err_align_q <= 1'b0;
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= bus.engine_busy;
      eng_q       <= engine_act;
      rd_ok_q     <= rd_ok_d;
      err_oor_q   <= err_oor_q | oor_hit;
      err_align_q <= err_align_q | mis_hit;
      wr_count_q  <= wr_count_d;
    end
  end

  // Array outputs are not reset, so every data path is gated by a reset-cleared qualifier.
  assign bus.bram_data_1 = (eng_q && rd_ok_q[0]) ? rd_data[0] : '0;
  assign bus.bram_data_2 = (eng_q && rd_ok_q[1]) ? rd_data[1] : '0;
  assign bus.bram_data_3 = (eng_q && rd_ok_q[2]) ? rd_data[2] : '0;
  assign bus.host_rvalid = rst_n && (state_q == ST_HOST_RSP);
  assign bus.host_rdata  = (bus.host_rvalid && rd_ok_q[0]) ? rd_data[0] : '0;
  assign bus.err_oor     = err_oor_q;
  assign bus.err_align   = err_align_q;
  assign bus.wr_count    = wr_count_q;

endmodule

// File: tb/tb_frodo_bram_server.sv
// tb/tb_frodo_bram_server.sv - directed table-driven bench for frodo_bram_server
module tb_frodo_bram_server;
  import frodo_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  frodo_bram_server_if #(.ADDR_W(32)) bus ();

  frodo_bram_server #(.DEPTH_WORDS(4096), .ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
  } host_vec_t;

  host_vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic host_op(input logic we, input logic [31:0] addr,
                         input logic [63:0] wdata, input logic [63:0] exp);
    bus.host_req_valid = 1'b1;
    bus.host_we        = we;
    bus.host_addr      = addr;
    bus.host_wdata     = wdata;
    #1;
    chk("host_ready", 64'(bus.host_req_ready), 64'd1);
    tick();
    bus.host_req_valid = 1'b0;
    if (we) begin
      chk("wr_no_rvalid", 64'(bus.host_rvalid), 64'd0);
    end else begin
      chk("rd_rvalid", 64'(bus.host_rvalid), 64'd1);
      chk("rd_data", bus.host_rdata, exp);
      tick();
      chk("rvalid_pulse", 64'(bus.host_rvalid), 64'd0);
    end
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_ready"}, 64'(bus.host_req_ready), 64'd0);
    chk({nm, "_rvalid"}, 64'(bus.host_rvalid), 64'd0);
    chk({nm, "_rdata"}, bus.host_rdata, 64'd0);
    chk({nm, "_d1"}, bus.bram_data_1, 64'd0);
    chk({nm, "_d2"}, bus.bram_data_2, 64'd0);
    chk({nm, "_d3"}, bus.bram_data_3, 64'd0);
    chk({nm, "_oor"}, 64'(bus.err_oor), 64'd0);
    chk({nm, "_align"}, 64'(bus.err_align), 64'd0);
    chk({nm, "_wrcnt"}, 64'(bus.wr_count), 64'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h40,   64'h1111_2222_3333_4444, 64'h0};
    vecs[1] = '{1'b0, 32'h40,   64'h0,                   64'h1111_2222_3333_4444};
    vecs[2] = '{1'b1, 32'h48,   64'h5555_6666_7777_8888, 64'h0};
    vecs[3] = '{1'b1, 32'h80,   64'h0123_4567_89AB_CDEF, 64'h0};
    vecs[4] = '{1'b0, 32'h48,   64'h0,                   64'h5555_6666_7777_8888};
    vecs[5] = '{1'b0, 32'h80,   64'h0,                   64'h0123_4567_89AB_CDEF};
    vecs[6] = '{1'b1, 32'h7FF8, 64'hDEAD_BEEF_CAFE_F00D, 64'h0};
    vecs[7] = '{1'b0, 32'h7FF8, 64'h0,                   64'hDEAD_BEEF_CAFE_F00D};

    rst_n = 1'b0;
    bus.bram_addr_1 = '0; bus.bram_addr_2 = '0; bus.bram_addr_3 = '0;
    bus.save_wen = 1'b0; bus.save_data = '0; bus.engine_busy = 1'b0;
    bus.host_req_valid = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    tick();
    tick();
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", 64'(bus.host_req_ready), 64'd1);

    for (int i = 0; i < 8; i++)
      host_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
    chk("table_oor", 64'(bus.err_oor), 64'd0);
    chk("table_align", 64'(bus.err_align), 64'd0);

    // Engine: busy rises, addresses are honoured from the ENGINE cycle on.
    bus.engine_busy = 1'b1;
    tick();
    chk("engine_ready_low", 64'(bus.host_req_ready), 64'd0);
    bus.bram_addr_1 = 32'h40; bus.bram_addr_2 = 32'h48; bus.bram_addr_3 = 32'h40;
    tick();
    chk("eng_d1", bus.bram_data_1, 64'h1111_2222_3333_4444);
    chk("eng_d2", bus.bram_data_2, 64'h5555_6666_7777_8888);
    chk("eng_d3", bus.bram_data_3, 64'h1111_2222_3333_4444);
    bus.bram_addr_1 = 32'h80; bus.bram_addr_2 = 32'h80;
    bus.save_wen = 1'b1; bus.save_data = 64'hAAAA_AAAA_AAAA_AAAA;
    tick();
    chk("collide_d1_old", bus.bram_data_1, 64'h0123_4567_89AB_CDEF);
    chk("collide_d2_old", bus.bram_data_2, 64'h0123_4567_89AB_CDEF);
    chk("wrcnt_1", 64'(bus.wr_count), 64'd1);
    bus.save_wen = 1'b0;
    tick();
    chk("collide_d1_new", bus.bram_data_1, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("collide_d3", bus.bram_data_3, 64'h1111_2222_3333_4444);
    bus.bram_addr_2 = 32'h88; bus.save_wen = 1'b1; bus.save_data = 64'h0F0F_0F0F_0F0F_0F0F;
    tick();
    chk("wrcnt_2", 64'(bus.wr_count), 64'd2);
    bus.save_wen = 1'b0; bus.engine_busy = 1'b0;
    bus.bram_addr_1 = '0; bus.bram_addr_2 = '0; bus.bram_addr_3 = '0;
    tick();
    tick();
    chk("idle_d1_zero", bus.bram_data_1, 64'd0);
    chk("idle_wrcnt_hold", 64'(bus.wr_count), 64'd2);

    // save_wen outside ENGINE must not touch the array or the counter.
    bus.bram_addr_2 = 32'h40; bus.save_wen = 1'b1; bus.save_data = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    bus.save_wen = 1'b0; bus.bram_addr_2 = '0;
    chk("idle_save_wrcnt", 64'(bus.wr_count), 64'd2);
    host_op(1'b0, 32'h40, 64'h0, 64'h1111_2222_3333_4444);
    host_op(1'b0, 32'h88, 64'h0, 64'h0F0F_0F0F_0F0F_0F0F);

    // Out-of-range and misaligned host accesses.
    host_op(1'b0, 32'h8 * 4096, 64'h0, 64'h0);
    chk("oor_set", 64'(bus.err_oor), 64'd1);
    chk("oor_no_align", 64'(bus.err_align), 64'd0);
    host_op(1'b1, 32'h44, 64'h9999_8888_7777_6666, 64'h0);
    chk("align_set", 64'(bus.err_align), 64'd1);
    host_op(1'b0, 32'h40, 64'h0, 64'h9999_8888_7777_6666);

    // Host request arriving with engine_busy rise is held off until the engine is done.
    bus.host_req_valid = 1'b1; bus.host_we = 1'b0; bus.host_addr = 32'h48;
    bus.engine_busy = 1'b1;
    #1;
    chk("prio_ready_low", 64'(bus.host_req_ready), 64'd0);
    tick();
    chk("prio_no_rvalid", 64'(bus.host_rvalid), 64'd0);
    tick();
    chk("prio_engine_ready", 64'(bus.host_req_ready), 64'd0);
    chk("prio_wrcnt_clear", 64'(bus.wr_count), 64'd0);
    bus.engine_busy = 1'b0;
    tick();
    chk("prio_ready_back", 64'(bus.host_req_ready), 64'd1);
    tick();
    bus.host_req_valid = 1'b0;
    chk("prio_rvalid", 64'(bus.host_rvalid), 64'd1);
    chk("prio_rdata", bus.host_rdata, 64'h5555_6666_7777_8888);
    tick();

    // Reset while a host response is pending.
    bus.host_req_valid = 1'b1; bus.host_we = 1'b0; bus.host_addr = 32'h80;
    tick();
    bus.host_req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_rvalid", 64'(bus.host_rvalid), 64'd0);
    chk("rst_rsp_rdata", bus.host_rdata, 64'd0);
    tick();
    chk_idle_outputs("midreset");
    rst_n = 1'b1;
    tick();
    host_op(1'b0, 32'h80, 64'h0, 64'hAAAA_AAAA_AAAA_AAAA);
    host_op(1'b0, 32'h40, 64'h0, 64'h9999_8888_7777_6666);
    chk("post_rst_oor", 64'(bus.err_oor), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
